// File: rtl/rr_arbiter_n.sv
// Parametrised N-way round-robin arbiter with registered one-hot grant,
// per-requester grant lock and a bounded hold so a locked owner cannot starve others.
module rr_arbiter_n #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [IDX_W-1:0]     ptr;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 keep;
    logic [IDX_W-1:0]     base;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [IDX_W-1:0]     off;
    logic [IDX_W-1:0]     win;
    int                   sum;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // The current owner is held in gnt_idx; base is where the circular scan starts.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        keep    = gnt_valid && req[gnt_idx] && lock[gnt_idx]
                  && (MAX_HOLD == 0 || int'(hold_cnt) < MAX_HOLD);
        base    = gnt_valid ? next_idx(gnt_idx) : ptr;
        shifted = {req, req} >> base;
        rot     = shifted[NUM_REQ-1:0];
        found   = 1'b0;
        off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = int'(base) + int'(off);
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win = IDX_W'(sum);
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (keep) begin
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        end else if (found) begin
            gnt       <= NUM_REQ'(1) << win;
            gnt_valid <= 1'b1;
            gnt_idx   <= win;
            ptr       <= next_idx(win);
            hold_cnt  <= HOLD_W'(1);
        end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n: directed vectors with literal expectations
// plus a per-cycle comparison against an integer-level round-robin model.
module tb_rr_arbiter_n;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;

    int n_checks = 0;
    int n_fail   = 0;

    int               m_owner  = -1;
    int               m_ptr    = 0;
    int               m_hold   = 0;
    logic [NUM_REQ-1:0] prev_req = '0;
    bit               checking = 1'b0;

    rr_arbiter_n #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit bit_set(input logic [NUM_REQ-1:0] v, input int i);
        return ((v >> i) & NUM_REQ'(1)) != '0;
    endfunction

    // Integer model: owner is -1 when idle; ARB scans circularly from a start index.
    function automatic void model_step();
        int start;
        int w;
        bit keep;
        prev_req = req;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            return;
        end
        keep = (m_owner >= 0) && bit_set(req, m_owner) && bit_set(lock, m_owner)
               && (MAX_HOLD == 0 || m_hold < MAX_HOLD);
        if (keep) begin
            m_hold++;
            return;
        end
        start = (m_owner >= 0) ? (m_owner + 1) % NUM_REQ : m_ptr;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && bit_set(req, (start + k) % NUM_REQ)) w = (start + k) % NUM_REQ;
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = (w + 1) % NUM_REQ;
            m_hold  = 1;
        end else begin
            m_owner = -1;
            m_hold  = 0;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("inv_valid_or", 32'(gnt_valid), 32'(|gnt));
            check("inv_gnt_follows_req", 32'(gnt & ~prev_req), 32'd0);
        end
    end

    task automatic step(input logic r, input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ-1:0] lk);
        reset = r;
        req   = rq;
        lock  = lk;
        @(posedge clk);
        #1;
        checking = 1'b1;
    endtask

    task automatic expect_gnt(input string name, input logic [NUM_REQ-1:0] g);
        int idx;
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (bit_set(g, i)) idx = i;
        check({name, "_gnt"}, 32'(gnt), 32'(g));
        check({name, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({name, "_valid"}, 32'(gnt_valid), 32'(|g));
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_rot  [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                              4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [NUM_REQ-1:0] exp_lock [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                              4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                              4'b0001, 4'b0001, 4'b0001, 4'b0010};

        // Reset held with all requesting: no grant.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'b1111, 4'b0000);
            expect_gnt("reset_hold", 4'b0000);
        end

        // Full rotation starting from requester 0.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 4'b0000);
            expect_gnt("rotate_all", exp_rot[i]);
        end

        // Sparse requests: bits 1 and 3 never granted.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0101, 4'b0000);
            expect_gnt("sparse", (i % 2 == 0) ? 4'b0001 : 4'b0100);
        end

        // Lock held by requester 0 is cut off after MAX_HOLD cycles.
        step(1'b1, 4'b0000, 4'b0000);
        expect_gnt("reset_again", 4'b0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'b1111, 4'b0001);
            expect_gnt("hold_limit", exp_lock[i]);
        end

        // Single requester gets the grant every cycle, then drops to idle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1000, 4'b0000);
            expect_gnt("sole_req", 4'b1000);
        end
        step(1'b0, 4'b0000, 4'b0000);
        expect_gnt("drop_idle", 4'b0000);

        // Sole locked requester past the hold limit keeps the grant without a gap.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b1000, 4'b1000);
            expect_gnt("sole_locked", 4'b1000);
        end
        // Lock alone never holds a grant once req is gone.
        step(1'b0, 4'b0000, 4'b1000);
        expect_gnt("lock_no_req", 4'b0000);

        // Reset mid-grant drops it and returns the pointer to 0.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        expect_gnt("pre_reset", 4'b0100);
        step(1'b1, 4'b1111, 4'b0000);
        expect_gnt("mid_reset", 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        expect_gnt("post_reset", 4'b0001);
        step(1'b0, 4'b1111, 4'b0000);
        expect_gnt("post_reset_next", 4'b0010);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
